bcd_operand_loader: RTL

Upstream stage for the 4-digit BCD divisibility-by-11 checker. It builds a packed BCD operand either from digits entered serially (keypad-style) or from an internal BCD sweep counter (0000..9999). It presents the operand over a valid/ready handshake whose data feeds the checker's 16-bit INPUT directly. Sweep mode allows exhaustive on-board exercise of the checker.

---
 rtl/bcd_operand_loader_if.sv | 28 ++
 rtl/bcd_operand_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_operand_loader_if.sv
// Handshake and control bundle between the BCD operand loader and its neighbours.
// The slave modport is the loader's view; the master modport is the driver's view.
interface bcd_operand_loader_if #(
    parameter int DIGITS = 4
);
    logic [3:0]          digit_in;
    logic                digit_valid;
    logic                clear;
    logic                commit;
    logic                sweep_start;
    logic                out_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                digit_err;
    logic [2:0]          count;
    logic                busy;
    logic                sweep_done;

    modport slave (
        input  digit_in, digit_valid, clear, commit, sweep_start, out_ready,
        output bcd_out, bcd_valid, digit_err, count, busy, sweep_done
    );

    modport master (
        output digit_in, digit_valid, clear, commit, sweep_start, out_ready,
        input  bcd_out, bcd_valid, digit_err, count, busy, sweep_done
    );
endinterface

// File: rtl/bcd_operand_loader.sv
// Builds a packed BCD operand from keypad digits or from a 0..all-nines sweep
// counter and offers it downstream over a valid/ready handshake.
module bcd_operand_loader #(
    parameter int DIGITS = 4
) (
    input logic                clk,
    input logic                reset_n,
    bcd_operand_loader_if.slave bus
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, HOLD, SWEEP, DONE} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   entry_reg, entry_next;
    logic [2:0]     count_reg, count_next;
    logic [W-1:0]   bcd_out_reg, bcd_out_next;
    logic           bcd_valid_reg, bcd_valid_next;
    logic           digit_err_reg, digit_err_next;
    logic           busy_reg, busy_next;
    logic           sweep_done_reg, sweep_done_next;

    logic [DIGITS-1:0] nine;
    logic [W-1:0]      bcd_inc;
    logic              all_nines;
    logic              transfer;

    // A digit receives the carry only when every lower digit is 9.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_inc
        logic [3:0] d;
        logic       cin;
        assign d        = bcd_out_reg[4*gi +: 4];
        assign nine[gi] = (d == 4'd9);
        if (gi == 0) begin : g_lsd
            assign cin = 1'b1;
        end else begin : g_upper
            assign cin = &nine[gi-1:0];
        end
        assign bcd_inc[4*gi +: 4] = (cin && nine[gi]) ? 4'd0 : d + {3'b000, cin};
    end

    assign all_nines = &nine;
    assign transfer  = bcd_valid_reg && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            entry_reg      <= '0;
            count_reg      <= '0;
            bcd_out_reg    <= '0;
            bcd_valid_reg  <= 1'b0;
            digit_err_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            sweep_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            entry_reg      <= entry_next;
            count_reg      <= count_next;
            bcd_out_reg    <= bcd_out_next;
            bcd_valid_reg  <= bcd_valid_next;
            digit_err_reg  <= digit_err_next;
            busy_reg       <= busy_next;
            sweep_done_reg <= sweep_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        entry_next      = entry_reg;
        count_next      = count_reg;
        bcd_out_next    = bcd_out_reg;
        bcd_valid_next  = bcd_valid_reg;
        digit_err_next  = 1'b0;
        busy_next       = busy_reg;
        sweep_done_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.clear) begin
                    entry_next = '0;
                    count_next = '0;
                end else if (bus.commit) begin
                    bcd_out_next   = entry_reg;
                    bcd_valid_next = 1'b1;
                    state_next     = HOLD;
                end else if (bus.sweep_start) begin
                    bcd_out_next   = '0;
                    bcd_valid_next = 1'b1;
                    busy_next      = 1'b1;
                    state_next     = SWEEP;
                end else if (bus.digit_valid) begin
                    if (bus.digit_in <= 4'd9) begin
                        entry_next = {entry_reg[W-5:0], bus.digit_in};
                        if (count_reg != 3'(DIGITS)) begin
                            count_next = count_reg + 3'd1;
                        end
                    end else begin
                        digit_err_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (transfer) begin
                    bcd_valid_next = 1'b0;
                    entry_next     = '0;
                    count_next     = '0;
                    state_next     = IDLE;
                end
            end
            SWEEP: begin
                if (bus.clear) begin
                    bcd_valid_next = 1'b0;
                    busy_next      = 1'b0;
                    entry_next     = '0;
                    count_next     = '0;
                    state_next     = IDLE;
                end else if (transfer) begin
                    if (all_nines) begin
                        // Last value accepted: stop without wrapping to zero.
                        bcd_valid_next  = 1'b0;
                        busy_next       = 1'b0;
                        sweep_done_next = 1'b1;
                        state_next      = DONE;
                    end else begin
                        bcd_out_next = bcd_inc;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.bcd_out    = bcd_out_reg;
    assign bus.bcd_valid  = bcd_valid_reg;
    assign bus.digit_err  = digit_err_reg;
    assign bus.count      = count_reg;
    assign bus.busy       = busy_reg;
    assign bus.sweep_done = sweep_done_reg;
endmodule
